ksa_swap_fsm: RTL



---
 rtl/ksa_pkg.sv | 23 ++
 rtl/ksa_swap_fsm_if.sv | 25 ++
 rtl/ksa_key_sel.sv | 20 ++
 rtl/ksa_swap_fsm.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key-scheduling and downstream stages.
package ksa_pkg;

    localparam int KEY_BYTES_DEF = 3;
    localparam int S_DEPTH       = 256;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        CAP_I,
        RD_J,
        CAP_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;

    // Width of a key-byte index; never zero, even for a one-byte key.
    function automatic int kidx_width(input int key_bytes);
        return (key_bytes > 1) ? $clog2(key_bytes) : 1;
    endfunction

endpackage

// File: rtl/ksa_swap_fsm_if.sv
// Single-port S memory bus: the controller drives a registered address and
// write strobe, and the memory returns read data for the current address.
interface ksa_swap_fsm_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output mem_addr,
        output wr_data,
        output wr_en,
        input  rd_data
    );

    modport slave (
        input  mem_addr,
        input  wr_data,
        input  wr_en,
        output rd_data
    );
endinterface

// File: rtl/ksa_key_sel.sv
// Combinational key byte select; byte 0 is the most significant byte of key.
module ksa_key_sel
    import ksa_pkg::*;
#(
    parameter  int KEY_BYTES = KEY_BYTES_DEF,
    localparam int KIDX_W    = kidx_width(KEY_BYTES)
) (
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [KIDX_W-1:0]      kidx,
    output logic [7:0]             key_byte
);

    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx == KIDX_W'(k)) key_byte = key[8*(KEY_BYTES-1-k) +: 8];
        end
    end

endmodule

// File: rtl/ksa_swap_fsm.sv
// RC4 key schedule: for i = 0..255, j += s[i] + key[i mod KEY_BYTES], swap s[i]/s[j].
// Six cycles per i over a single-port S memory, then finish is held for the PRGA.
module ksa_swap_fsm
    import ksa_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEF,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    ksa_swap_fsm_if.master         mem,
    output logic                   finish
);

    localparam int KIDX_W = kidx_width(KEY_BYTES);

    ksa_state_t             state, state_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [ADDR_W-1:0]      i, i_d, j, j_d;
    logic [KIDX_W-1:0]      kidx, kidx_d;
    logic [DATA_W-1:0]      si, si_d, sj, sj_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   wen_q, wen_d;
    logic                   finish_d;
    logic [7:0]             key_byte;

    ksa_key_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
        .key      (key_q),
        .kidx     (kidx),
        .key_byte (key_byte)
    );

    assign mem.mem_addr = addr_q;
    assign mem.wr_data  = wdata_q;
    assign mem.wr_en    = wen_q;

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state;
        key_d    = key_q;
        i_d      = i;
        j_d      = j;
        kidx_d   = kidx;
        si_d     = si;
        sj_d     = sj;
        addr_d   = '0;
        wdata_d  = '0;
        wen_d    = 1'b0;
        finish_d = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    key_d   = secret_key;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = RD_I;
                end
            end
            RD_I: begin
                addr_d  = i;
                state_d = CAP_I;
            end
            CAP_I: begin
                si_d    = mem.rd_data;
                j_d     = j + ADDR_W'(mem.rd_data) + ADDR_W'(key_byte);
                state_d = RD_J;
            end
            RD_J: begin
                addr_d  = j;
                state_d = CAP_J;
            end
            CAP_J: begin
                sj_d    = mem.rd_data;
                state_d = WR_I;
            end
            WR_I: begin
                addr_d  = i;
                wdata_d = sj;
                wen_d   = 1'b1;
                state_d = WR_J;
            end
            WR_J: begin
                addr_d  = j;
                wdata_d = si;
                wen_d   = 1'b1;
                if (&i) begin
                    state_d = DONE;
                end else begin
                    i_d     = i + ADDR_W'(1);
                    kidx_d  = (kidx == KIDX_W'(KEY_BYTES-1)) ? '0 : kidx + KIDX_W'(1);
                    state_d = RD_I;
                end
            end
            DONE: begin
                // Guarantee at least one cycle of finish even if start already dropped.
                finish_d = start || !finish;
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            key_q   <= '0;
            i       <= '0;
            j       <= '0;
            kidx    <= '0;
            si      <= '0;
            sj      <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            finish  <= 1'b0;
        end else begin
            state   <= state_d;
            key_q   <= key_d;
            i       <= i_d;
            j       <= j_d;
            kidx    <= kidx_d;
            si      <= si_d;
            sj      <= sj_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            finish  <= finish_d;
        end
    end

endmodule
